// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the two-stage ALU pipeline.
//   - alu_op_e : the operation selected by the decoder and held in stage 1
//   - INS_*    : bit positions of the packed control word ins[6:0]
//                  [6] opb5, [5] funct7b5, [4:2] funct3, [1:0] ALUOp
//   - decode_funct3 : the ALUOp=10 decode, shared so that the ALUOp=11
//                     fallback is guaranteed to match it
// Optional feature macro: ALU_MUL_EN (see alu_pipe_dec / alu_pipe).
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_MUL
  } alu_op_e;

  localparam int INS_W         = 7;
  localparam int INS_OPB5      = 6;
  localparam int INS_F7B5      = 5;
  localparam int INS_F3_MSB    = 4;
  localparam int INS_F3_LSB    = 2;
  localparam int INS_ALUOP_MSB = 1;
  localparam int INS_ALUOP_LSB = 0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_EXT   = 2'b11;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  // Subtract needs both opb5 and funct7b5: an immediate form (opb5=0) with
  // funct7b5 set is still an add. Shifts only look at funct7b5.
  function automatic alu_op_e decode_funct3(input logic [2:0] funct3,
                                            input logic       funct7b5,
                                            input logic       opb5);
    alu_op_e op;
    op = ALU_ADD;
    case (funct3)
      F3_ADDSUB: op = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
      F3_SLL:    op = ALU_SLL;
      F3_SLT:    op = ALU_SLT;
      F3_SLTU:   op = ALU_SLTU;
      F3_XOR:    op = ALU_XOR;
      F3_SR:     op = funct7b5 ? ALU_SRA : ALU_SRL;
      F3_OR:     op = ALU_OR;
      F3_AND:    op = ALU_AND;
      default:   op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_pipe_dec.sv
// ---------------------------------------------------------------------------
// alu_pipe_dec
// Combinational decode of the packed control word into an alu_op_e.
// Every ins value maps to a defined operation.
// Optional feature: ALU_MUL_EN -- when defined ALUOp=11 selects multiply,
// otherwise ALUOp=11 decodes exactly like ALUOp=10.
// Ports:
//   ins  in   [6:0]    {opb5, funct7b5, funct3[2:0], ALUOp[1:0]}
//   op   out  alu_op_e selected operation
// ---------------------------------------------------------------------------
module alu_pipe_dec
  import alu_pkg::*;
(
  input  logic [INS_W-1:0] ins,
  output alu_op_e          op
);

  logic [1:0] w_aluop;
  logic [2:0] w_funct3;
  logic       w_funct7b5;
  logic       w_opb5;
  alu_op_e    w_funct_op;

  assign w_aluop    = ins[INS_ALUOP_MSB:INS_ALUOP_LSB];
  assign w_funct3   = ins[INS_F3_MSB:INS_F3_LSB];
  assign w_funct7b5 = ins[INS_F7B5];
  assign w_opb5     = ins[INS_OPB5];
  assign w_funct_op = decode_funct3(w_funct3, w_funct7b5, w_opb5);

  always_comb begin
    op = ALU_ADD;
    case (w_aluop)
      ALUOP_ADD:   op = ALU_ADD;
      ALUOP_SUB:   op = ALU_SUB;
      ALUOP_FUNCT: op = w_funct_op;
`ifdef ALU_MUL_EN
      ALUOP_EXT:   op = ALU_MUL;
`else
      ALUOP_EXT:   op = w_funct_op;
`endif
      default:     op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
// Two-stage pipelined integer ALU with valid/ready handshakes on both sides.
//   S1 registers the decoded operation and both operands.
//   S2 registers result, zero flag and sign flag.
// An op transferred in on one edge is presented on the output after the
// following edge; one op per cycle sustained with out_ready high.
// Optional feature: ALU_MUL_EN -- adds a low-half multiplier on ALUOp=11.
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   synchronous active-high reset, highest priority
//   flush      in   discard everything in flight (and the op offered now)
//   in_valid   in   op offered
//   in_ready   out  op will be accepted this cycle
//   ins        in   [6:0] packed control (see alu_pkg)
//   src_a      in   [XLEN-1:0] operand A
//   src_b      in   [XLEN-1:0] operand B
//   out_valid  out  result presented
//   out_ready  in   consumer takes result this cycle
//   result     out  [XLEN-1:0] registered result
//   zero       out  registered result == 0
//   sign       out  registered result[XLEN-1]
// ---------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INS_W-1:0] ins,
  input  logic [XLEN-1:0]  src_a,
  input  logic [XLEN-1:0]  src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic             sign
);

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  alu_op_e w_dec_op;

  alu_pipe_dec u_dec (
    .ins (ins),
    .op  (w_dec_op)
  );

  // -------------------------------------------------------------------------
  // Stage registers
  // -------------------------------------------------------------------------
  logic            r_s1_valid;
  alu_op_e         r_s1_op;
  logic [XLEN-1:0] r_s1_a;
  logic [XLEN-1:0] r_s1_b;

  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_sign;

  // -------------------------------------------------------------------------
  // Handshake control
  // S2 may load whenever it is empty or being drained this cycle; S1 moves
  // into S2 on the same condition, so S1 can refill whenever it is empty or
  // moving. in_ready deliberately ignores in_valid.
  // -------------------------------------------------------------------------
  logic w_s2_adv;
  logic w_accept;

  assign w_s2_adv = ~r_out_valid | out_ready;
  assign in_ready = ~r_s1_valid | w_s2_adv;
  assign w_accept = in_valid & in_ready;

  // -------------------------------------------------------------------------
  // Datapath (operates on S1 contents)
  // -------------------------------------------------------------------------
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_sll;
  logic [XLEN-1:0] w_srl;
  logic [XLEN-1:0] w_sra;
  logic [XLEN-1:0] w_slt;
  logic [XLEN-1:0] w_sltu;
`ifdef ALU_MUL_EN
  logic [XLEN-1:0] w_mul;
`endif
  logic [XLEN-1:0] w_alu_res;
  logic            w_alu_zero;

  // Only the low SHW bits of B form the shift amount; higher bits are ignored.
  assign w_shamt = r_s1_b[SHW-1:0];
  assign w_sum   = r_s1_a + r_s1_b;
  assign w_diff  = r_s1_a - r_s1_b;
  assign w_sll   = r_s1_a << w_shamt;
  assign w_srl   = r_s1_a >> w_shamt;
  assign w_sra   = $signed(r_s1_a) >>> w_shamt;
  assign w_slt   = {{(XLEN-1){1'b0}}, ($signed(r_s1_a) < $signed(r_s1_b))};
  assign w_sltu  = {{(XLEN-1){1'b0}}, (r_s1_a < r_s1_b)};
`ifdef ALU_MUL_EN
  // Low half of the product is identical for signed and unsigned operands.
  assign w_mul   = r_s1_a * r_s1_b;
`endif

  always_comb begin
    w_alu_res = w_sum;
    case (r_s1_op)
      ALU_ADD:  w_alu_res = w_sum;
      ALU_SUB:  w_alu_res = w_diff;
      ALU_SLL:  w_alu_res = w_sll;
      ALU_SLT:  w_alu_res = w_slt;
      ALU_SLTU: w_alu_res = w_sltu;
      ALU_XOR:  w_alu_res = r_s1_a ^ r_s1_b;
      ALU_SRL:  w_alu_res = w_srl;
      ALU_SRA:  w_alu_res = w_sra;
      ALU_OR:   w_alu_res = r_s1_a | r_s1_b;
      ALU_AND:  w_alu_res = r_s1_a & r_s1_b;
`ifdef ALU_MUL_EN
      ALU_MUL:  w_alu_res = w_mul;
`endif
      default:  w_alu_res = w_sum;
    endcase
  end

  assign w_alu_zero = (w_alu_res == '0);

  // -------------------------------------------------------------------------
  // Pipeline state
  // Reset beats flush, flush beats handshakes. A flush still lets a result
  // that is being taken this cycle count as consumed: out_valid simply drops
  // and the held result/flags stay put, so nothing stale reappears.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= ALU_ADD;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_sign      <= 1'b0;
    end else if (flush) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        // Leave the output registers untouched on a bubble so the last
        // result is not overwritten with garbage from an empty S1.
        if (r_s1_valid) begin
          r_result <= w_alu_res;
          r_zero   <= w_alu_zero;
          r_sign   <= w_alu_res[XLEN-1];
        end
      end

      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_op    <= w_dec_op;
        r_s1_a     <= src_a;
        r_s1_b     <= src_b;
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign sign      = r_sign;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      ins;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            sign;

  int n_tests;
  int n_fail;

  // ins = {opb5, funct7b5, funct3, ALUOp}
  localparam logic [6:0] I_ADD    = 7'b0000000;
  localparam logic [6:0] I_SUB    = 7'b0000001;
  localparam logic [6:0] I_SLL    = 7'b0000110;
  localparam logic [6:0] I_SLT    = 7'b0001010;
  localparam logic [6:0] I_SLTU   = 7'b0001110;
  localparam logic [6:0] I_XOR    = 7'b0010010;
  localparam logic [6:0] I_SRL    = 7'b0010110;
  localparam logic [6:0] I_SRA    = 7'b0110110;
  localparam logic [6:0] I_OR     = 7'b0011010;
  localparam logic [6:0] I_AND    = 7'b0011110;
  localparam logic [6:0] I_RSUB   = 7'b1100010;
  localparam logic [6:0] I_F7ONLY = 7'b0100010;
  localparam logic [6:0] I_B5ONLY = 7'b1000010;
  localparam logic [6:0] I_EXT0   = 7'b0000011;
  localparam logic [6:0] I_EXT4   = 7'b0010011;

  alu_pipe #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ins       (ins),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .sign      (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    in_valid = 1'b1;
    ins      = i;
    src_a    = a;
    src_b    = b;
  endtask

  // Single isolated op with out_ready high: accept edge, then S2 edge.
  task automatic run_op(input string tag, input logic [6:0] i,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp);
    drive(i, a, b);
    step();
    in_valid = 1'b0;
    step();
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".result"}, 64'(result), 64'(exp));
    chk({tag, ".zero"}, 64'(zero), 64'(exp == '0));
    chk({tag, ".sign"}, 64'(sign), 64'(exp[XLEN-1]));
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ins       = '0;
    src_a     = '0;
    src_b     = '0;

    // ---------------- reset state
    step();
    step();
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.zero", 64'(zero), 64'd0);
    chk("rst.sign", 64'(sign), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);

    // ---------------- back-to-back add / sub / slt
    drive(I_ADD, 32'd5, 32'd7);
    step();
    chk("b2b.in_ready0", 64'(in_ready), 64'd1);
    drive(I_SUB, 32'd5, 32'd7);
    step();
    chk("b2b.add.valid", 64'(out_valid), 64'd1);
    chk("b2b.add.result", 64'(result), 64'd12);
    chk("b2b.add.sign", 64'(sign), 64'd0);
    drive(I_SLT, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("b2b.sub.valid", 64'(out_valid), 64'd1);
    chk("b2b.sub.result", 64'(result), 64'hFFFF_FFFE);
    chk("b2b.sub.sign", 64'(sign), 64'd1);
    in_valid = 1'b0;
    step();
    chk("b2b.slt.valid", 64'(out_valid), 64'd1);
    chk("b2b.slt.result", 64'(result), 64'd1);
    chk("b2b.slt.sign", 64'(sign), 64'd0);
    step();
    chk("b2b.drain", 64'(out_valid), 64'd0);

    // ---------------- shifts, compares, logic, decode corners
    run_op("sra",    I_SRA,    32'h8000_0000, 32'h0000_0021, 32'hC000_0000);
    run_op("srl",    I_SRL,    32'h8000_0000, 32'h0000_0021, 32'h4000_0000);
    run_op("sub0",   I_SUB,    32'd3,         32'd3,         32'h0000_0000);
    run_op("sll",    I_SLL,    32'd1,         32'h0000_0024, 32'h0000_0010);
    run_op("sltu0",  I_SLTU,   32'hFFFF_FFFF, 32'd1,         32'd0);
    run_op("sltu1",  I_SLTU,   32'd1,         32'hFFFF_FFFF, 32'd1);
    run_op("slt0",   I_SLT,    32'd1,         32'hFFFF_FFFF, 32'd0);
    run_op("xor",    I_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    run_op("or",     I_OR,     32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0);
    run_op("and",    I_AND,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    run_op("rsub",   I_RSUB,   32'd10,        32'd3,         32'd7);
    run_op("f7only", I_F7ONLY, 32'd10,        32'd3,         32'd13);
    run_op("b5only", I_B5ONLY, 32'd10,        32'd3,         32'd13);
    run_op("wrap",   I_ADD,    32'hFFFF_FFFF, 32'd1,         32'd0);
`ifdef ALU_MUL_EN
    run_op("ext4",   I_EXT4,   32'h0001_0003, 32'd5,         32'h0005_000F);
`else
    run_op("ext4",   I_EXT4,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
`endif
    in_valid = 1'b0;
    step();
    chk("ops.drain", 64'(out_valid), 64'd0);

    // ---------------- backpressure: 3 ops offered while out_ready low
    out_ready = 1'b0;
    drive(I_ADD, 32'd1, 32'd1);
    #1;
    chk("bp.rdy1", 64'(in_ready), 64'd1);
    step();
    drive(I_ADD, 32'd2, 32'd2);
    #1;
    chk("bp.rdy2", 64'(in_ready), 64'd1);
    step();
    drive(I_ADD, 32'd3, 32'd3);
    #1;
    chk("bp.rdy3", 64'(in_ready), 64'd0);
    chk("bp.hold0.valid", 64'(out_valid), 64'd1);
    chk("bp.hold0.result", 64'(result), 64'd2);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("bp.hold%0d.result", k), 64'(result), 64'd2);
      chk($sformatf("bp.hold%0d.rdy", k), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release.rdy", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp.op2.valid", 64'(out_valid), 64'd1);
    chk("bp.op2.result", 64'(result), 64'd4);
    step();
    chk("bp.op3.valid", 64'(out_valid), 64'd1);
    chk("bp.op3.result", 64'(result), 64'd6);
    step();
    chk("bp.drain", 64'(out_valid), 64'd0);

    // ---------------- flush with 2 in flight and 1 offered
    drive(I_ADD, 32'd100, 32'd1);
    step();
    drive(I_ADD, 32'd200, 32'd1);
    step();
    chk("fl.pre.result", 64'(result), 64'd101);
    drive(I_ADD, 32'd300, 32'd1);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl.valid", 64'(out_valid), 64'd0);
    chk("fl.rdy", 64'(in_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("fl.quiet%0d", k), 64'(out_valid), 64'd0);
    end
    run_op("fl.after", I_ADD, 32'd10, 32'd20, 32'd30);

    // ---------------- reset mid-stream
    drive(I_SUB, 32'd0, 32'd1);
    step();
    drive(I_ADD, 32'd7, 32'd8);
    step();
    chk("mr.pre.result", 64'(result), 64'hFFFF_FFFF);
    chk("mr.pre.sign", 64'(sign), 64'd1);
    drive(I_ADD, 32'd9, 32'd9);
    reset = 1'b1;
    step();
    chk("mr.valid", 64'(out_valid), 64'd0);
    chk("mr.result", 64'(result), 64'd0);
    chk("mr.zero", 64'(zero), 64'd0);
    chk("mr.sign", 64'(sign), 64'd0);
    chk("mr.rdy", 64'(in_ready), 64'd1);
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("mr.quiet0", 64'(out_valid), 64'd0);
    step();
    chk("mr.quiet1", 64'(out_valid), 64'd0);

    // ---------------- ALUOp 11: multiply when enabled, else funct3 add
`ifdef ALU_MUL_EN
    run_op("ext0", I_EXT0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
`else
    run_op("ext0", I_EXT0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
